window_outlier_detector: RTL and testbench
==========================================

# window_outlier_detector

Downstream consumer of the `interface` stage's sample stream in the outlier-detection datapath. It takes each new Q16.16 sample and keeps a sliding window of the last 2^DEPTH_LOG2 accepted samples with a running sum. It classifies each incoming sample as an outlier when its absolute deviation from the window mean exceeds a fixed threshold. Outliers are reported but never inserted into the window, so the baseline stays robust.

## Interface
- DEPTH_LOG2, 3, log2 of window length N (N = 8 by default)
- THRESH, 32'h0002_0000, unsigned Q16.16 deviation threshold (2.0)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- x_in  input  32  signed Q16.16 sample (bit 16 = 1.0)
- in_valid  input  1  single-cycle strobe, x_in valid this cycle
- busy  output  1  high while a sample is in flight (state != IDLE)
- out_valid  output  1  one-cycle pulse, result outputs updated
- outlier  output  1  classification of last processed sample
- dev  output  32  unsigned Q16.16 |x - mean_before|, saturated
- mean  output  32  signed Q16.16 window mean after update
- window_full  output  1  window holds N accepted samples
- overrun  output  1  sticky: in_valid arrived while busy

## Operation
- Storage: N x 32 circular buffer, write pointer wptr (DEPTH_LOG2 bits), count (DEPTH_LOG2+1 bits, saturates at N), sum signed 32+DEPTH_LOG2 bits.
- mean = sum >>> DEPTH_LOG2 (arithmetic shift, floor toward -inf), truncated to 32 bits. It is always computed as sum/N, even while filling.
- FSM states: IDLE, DIFF, UPDATE, DONE.
- IDLE: on in_valid, latch x_in into xr, go to DIFF. Otherwise stay.
- DIFF: d = xr - mean (33-bit signed). dev_r = |d|, saturated to 32'h7FFF_FFFF. is_out = window_full && (dev_r > THRESH), strict compare. Go to UPDATE.
- UPDATE, when !is_out:
  - If count == N: sum <= sum - buf[wptr] + xr.
  - Else: sum <= sum + xr and count++.
  - buf[wptr] <= xr; wptr++ (wraps mod N).
- UPDATE, when is_out: window state unchanged. Go to DONE.
- DONE: register outlier = is_out, dev = dev_r, mean = updated mean. Pulse out_valid. Go to IDLE.
- During warm-up (count < N), outlier is forced to 0 and the sample is always inserted. dev is still reported against the partial mean.
- window_full = (count == N).
- in_valid while state != IDLE: the sample is dropped and overrun is set to 1. overrun clears only on reset.
- in_valid is ignored in the same cycle a sample is accepted; there is no queueing.

## Timing
- Reset (reset = 0, async) values:
  - state = IDLE.
  - busy, out_valid, outlier, window_full, overrun = 0.
  - dev, mean, sum, count, wptr = 0.
  - Buffer contents don't care, because count = 0 masks them.
- in_valid sampled high in IDLE at edge T:
  - busy = 1 from T to T+3.
  - out_valid high for exactly one cycle, from edge T+3 to T+4.
  - State is back in IDLE after edge T+3.
- Earliest next accepted in_valid is at edge T+4, giving throughput of 1 sample per 4 cycles.
- outlier, dev and mean hold their values between out_valid pulses.
- Reset asserted mid-operation aborts the sample immediately. No out_valid is produced. The window restarts empty.
- Pointer wrap: after N inserts wptr = 0, and the next insert replaces the oldest entry.

## Test plan
- Reset: hold reset = 0 with in_valid toggling. Required: all outputs 0, no out_valid. After release, the first out_valid arrives exactly 3 cycles after the first accepted strobe.
- Warm-up: feed 8 samples of 0x0001_0000 (1.0). Required: outlier = 0 on every pulse, window_full rises with the 8th out_valid, mean = 0x0001_0000.
- Positive outlier: after warm-up, feed 0x0004_0000 (4.0). Required: dev = 0x0003_0000, outlier = 1, mean stays 0x0001_0000. A following 1.0 sample gives dev = 0.
- Threshold boundary and insert: after warm-up at 1.0, feed 0x0003_0000. Required: dev = 0x0002_0000, outlier = 0 (strict compare), mean = 0x0001_4000 (10/8 = 1.25). Then feed 8 more samples of 1.0: mean returns to 0x0001_0000 after the 3.0 sample wraps out.
- Negative outlier: after warm-up at 1.0, feed 0xFFFE_0000 (-2.0). Required: dev = 0x0003_0000, outlier = 1, window unchanged. Feeding 0xFFFF_0000 (-1.0) gives dev = 0x0002_0000, outlier = 0.
- Overrun and mid-op reset: assert in_valid at T and T+1. Required: one out_valid at T+3 and overrun = 1 (sticky). Assert reset at T+2 of the next sample. Required: no out_valid, overrun = 0, count = 0.

Source files
------------

// File: rtl/window_outlier_detector.sv
// Sliding-window outlier detector for a Q16.16 sample stream.
// A sample is an outlier when its distance from the window mean exceeds THRESH; outliers are never stored.
module window_outlier_detector #(
    parameter int          DEPTH_LOG2 = 3,
    parameter logic [31:0] THRESH     = 32'h0002_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] x_in,
    input  logic        in_valid,
    output logic        busy,
    output logic        out_valid,
    output logic        outlier,
    output logic [31:0] dev,
    output logic [31:0] mean,
    output logic        window_full,
    output logic        overrun
);

    localparam int                N     = 1 << DEPTH_LOG2;
    localparam int                SW    = 32 + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] N_CNT = (DEPTH_LOG2 + 1)'(N);

    typedef enum logic [1:0] {IDLE, DIFF, UPDATE, DONE} state_t;

    state_t                  state;
    state_t                  next_state;
    logic [31:0]             xr;
    logic [31:0]             dev_r;
    logic                    is_out;
    logic [DEPTH_LOG2-1:0]   wptr;
    logic [DEPTH_LOG2:0]     count;
    logic signed [SW-1:0]    sum;
    logic [31:0]             buf_mem [N];

    logic                    full;
    logic [31:0]             mean_cur;
    logic signed [32:0]      diff;
    logic [32:0]             abs_d;
    logic [31:0]             dev_sat;
    logic signed [SW-1:0]    xr_ext;
    logic signed [SW-1:0]    old_ext;

    assign full     = (count == N_CNT);
    assign busy     = (state != IDLE);
    // Taking SW-bit sum bits [DEPTH_LOG2 +: 32] is the floor shift by DEPTH_LOG2, truncated to 32 bits.
    assign mean_cur = sum[DEPTH_LOG2 +: 32];
    assign diff     = $signed({xr[31], xr}) - $signed({mean_cur[31], mean_cur});
    assign abs_d    = diff[32] ? 33'(-diff) : 33'(diff);
    assign dev_sat  = (abs_d > 33'h0_7FFF_FFFF) ? 32'h7FFF_FFFF : abs_d[31:0];
    assign xr_ext   = SW'($signed(xr));
    assign old_ext  = SW'($signed(buf_mem[wptr]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = DIFF;
            DIFF:    next_state = UPDATE;
            UPDATE:  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xr          <= '0;
            dev_r       <= '0;
            is_out      <= 1'b0;
            wptr        <= '0;
            count       <= '0;
            sum         <= '0;
            out_valid   <= 1'b0;
            outlier     <= 1'b0;
            dev         <= '0;
            mean        <= '0;
            window_full <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (in_valid) xr <= x_in;
                end
                DIFF: begin
                    dev_r  <= dev_sat;
                    is_out <= full && (dev_sat > THRESH);
                end
                UPDATE: begin
                    if (!is_out) begin
                        if (full) begin
                            sum <= sum - old_ext + xr_ext;
                        end else begin
                            sum   <= sum + xr_ext;
                            count <= count + 1'b1;
                        end
                        wptr <= wptr + 1'b1;
                    end
                end
                DONE: begin
                    outlier     <= is_out;
                    dev         <= dev_r;
                    mean        <= mean_cur;
                    window_full <= full;
                    out_valid   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Stale buffer entries are harmless: count masks them until they are overwritten.
    always_ff @(posedge clk) begin
        if (state == UPDATE && !is_out) buf_mem[wptr] <= xr;
    end

endmodule

// File: tb/tb_window_outlier_detector.sv
// Self-checking bench for window_outlier_detector: directed scenarios plus randomized
// samples compared against a queue-based model of the accepted-sample window.
module tb_window_outlier_detector;

    localparam int     N      = 8;
    localparam longint THRESH = 64'h2_0000;
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] x_in = '0;
    logic        in_valid = 1'b0;
    logic        busy, out_valid, outlier, window_full, overrun;
    logic [31:0] dev, mean;

    int     checks = 0;
    int     failures = 0;
    longint model_q[$];

    window_outlier_detector dut (
        .clk(clk), .reset(reset), .x_in(x_in), .in_valid(in_valid),
        .busy(busy), .out_valid(out_valid), .outlier(outlier), .dev(dev),
        .mean(mean), .window_full(window_full), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Mean of the accepted window divided by N, rounded toward minus infinity.
    function automatic longint model_mean();
        longint s = 0;
        longint q;
        foreach (model_q[i]) s += model_q[i];
        q = s / N;
        if (s < 0 && (s % N) != 0) q -= 1;
        return q;
    endfunction

    function automatic void model_step(input logic [31:0] x, output logic eo,
                                       output logic [31:0] ed, output logic [31:0] em,
                                       output logic ewf);
        longint mb = model_mean();
        longint d  = longint'($signed(x)) - mb;
        longint ma;
        if (d < 0) d = -d;
        if (d > 64'h7FFF_FFFF) d = 64'h7FFF_FFFF;
        ed = d[31:0];
        eo = (model_q.size() == N) && (d > THRESH);
        if (!eo) begin
            model_q.push_back(longint'($signed(x)));
            if (model_q.size() > N) void'(model_q.pop_front());
        end
        ma  = model_mean();
        em  = ma[31:0];
        ewf = (model_q.size() == N);
    endfunction

    task automatic drive_sample(input logic [31:0] x, output int lat, output logic o,
                                output logic [31:0] d, output logic [31:0] m, output logic wf);
        @(negedge clk);
        x_in = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x_in = $urandom;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        o = outlier;
        d = dev;
        m = mean;
        wf = window_full;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_q.delete();
    endtask

    task automatic warm_up_ones();
        int lat;
        logic o, wf, eo, ewf;
        logic [31:0] d, m, ed, em;
        for (int i = 0; i < N; i++) begin
            drive_sample(ONE, lat, o, d, m, wf);
            model_step(ONE, eo, ed, em, ewf);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = i[0];
            x_in = $urandom;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_out_valid cycle %0d got=%b exp=0", i, out_valid);
            end
            checks++;
            if ({busy, outlier, window_full, overrun, dev, mean} !== '0) begin
                failures++;
                $display("[TB] FAIL reset_outputs cycle %0d got busy=%b outl=%b wf=%b ovr=%b dev=%h mean=%h exp all 0",
                         i, busy, outlier, window_full, overrun, dev, mean);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        model_q.delete();
    endtask

    task automatic test_warmup();
        int lat;
        logic o, wf, eo, ewf;
        logic [31:0] d, m, ed, em;
        for (int i = 0; i < N; i++) begin
            drive_sample(ONE, lat, o, d, m, wf);
            model_step(ONE, eo, ed, em, ewf);
            checks++;
            if (lat !== 3) begin
                failures++;
                $display("[TB] FAIL warmup_latency[%0d] got=%0d exp=3", i, lat);
            end
            checks++;
            if ({o, wf, d, m} !== {eo, ewf, ed, em}) begin
                failures++;
                $display("[TB] FAIL warmup_result[%0d] got outl=%b wf=%b dev=%h mean=%h exp outl=%b wf=%b dev=%h mean=%h",
                         i, o, wf, d, m, eo, ewf, ed, em);
            end
        end
        checks++;
        if ({window_full, mean} !== {1'b1, ONE}) begin
            failures++;
            $display("[TB] FAIL warmup_final got wf=%b mean=%h exp wf=1 mean=%h", window_full, mean, ONE);
        end
    endtask

    task automatic test_positive_outlier();
        int lat;
        logic o, wf, eo, ewf;
        logic [31:0] d, m, ed, em;
        drive_sample(32'h0004_0000, lat, o, d, m, wf);
        model_step(32'h0004_0000, eo, ed, em, ewf);
        checks++;
        if ({o, d, m} !== {1'b1, 32'h0003_0000, ONE}) begin
            failures++;
            $display("[TB] FAIL pos_outlier got outl=%b dev=%h mean=%h exp outl=1 dev=00030000 mean=00010000", o, d, m);
        end
        checks++;
        if ({o, wf, d, m} !== {eo, ewf, ed, em}) begin
            failures++;
            $display("[TB] FAIL pos_outlier_model got outl=%b wf=%b dev=%h mean=%h exp outl=%b wf=%b dev=%h mean=%h",
                     o, wf, d, m, eo, ewf, ed, em);
        end
        drive_sample(ONE, lat, o, d, m, wf);
        model_step(ONE, eo, ed, em, ewf);
        checks++;
        if ({o, d, m} !== {1'b0, 32'h0, ONE}) begin
            failures++;
            $display("[TB] FAIL pos_followup got outl=%b dev=%h mean=%h exp outl=0 dev=0 mean=00010000", o, d, m);
        end
    endtask

    task automatic test_threshold_insert();
        int lat;
        logic o, wf, eo, ewf;
        logic [31:0] d, m, ed, em;
        do_reset();
        warm_up_ones();
        drive_sample(32'h0003_0000, lat, o, d, m, wf);
        model_step(32'h0003_0000, eo, ed, em, ewf);
        checks++;
        if ({o, d, m} !== {1'b0, 32'h0002_0000, 32'h0001_4000}) begin
            failures++;
            $display("[TB] FAIL thresh_boundary got outl=%b dev=%h mean=%h exp outl=0 dev=00020000 mean=00014000", o, d, m);
        end
        for (int i = 0; i < N; i++) begin
            drive_sample(ONE, lat, o, d, m, wf);
            model_step(ONE, eo, ed, em, ewf);
            checks++;
            if ({o, wf, d, m} !== {eo, ewf, ed, em}) begin
                failures++;
                $display("[TB] FAIL thresh_refill[%0d] got outl=%b wf=%b dev=%h mean=%h exp outl=%b wf=%b dev=%h mean=%h",
                         i, o, wf, d, m, eo, ewf, ed, em);
            end
        end
        checks++;
        if (m !== ONE) begin
            failures++;
            $display("[TB] FAIL thresh_wrap_mean got=%h exp=%h", m, ONE);
        end
    endtask

    task automatic test_negative_outlier();
        int lat;
        logic o, wf, eo, ewf;
        logic [31:0] d, m, ed, em;
        do_reset();
        warm_up_ones();
        drive_sample(32'hFFFE_0000, lat, o, d, m, wf);
        model_step(32'hFFFE_0000, eo, ed, em, ewf);
        checks++;
        if ({o, d, m} !== {1'b1, 32'h0003_0000, ONE}) begin
            failures++;
            $display("[TB] FAIL neg_outlier got outl=%b dev=%h mean=%h exp outl=1 dev=00030000 mean=00010000", o, d, m);
        end
        drive_sample(32'hFFFF_0000, lat, o, d, m, wf);
        model_step(32'hFFFF_0000, eo, ed, em, ewf);
        checks++;
        if ({o, d} !== {1'b0, 32'h0002_0000}) begin
            failures++;
            $display("[TB] FAIL neg_inlier got outl=%b dev=%h exp outl=0 dev=00020000", o, d);
        end
        checks++;
        if ({wf, m} !== {ewf, em}) begin
            failures++;
            $display("[TB] FAIL neg_inlier_mean got wf=%b mean=%h exp wf=%b mean=%h", wf, m, ewf, em);
        end
    endtask

    task automatic test_overrun_and_midop_reset();
        int cyc;
        int extra;
        int lat;
        logic o, wf, eo, ewf;
        logic [31:0] d, m, ed, em;
        do_reset();
        @(negedge clk);
        x_in = ONE;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        x_in = 32'h0009_0000;
        @(posedge clk);
        #1;
        cyc = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        model_step(ONE, eo, ed, em, ewf);
        checks++;
        if (cyc !== 3) begin
            failures++;
            $display("[TB] FAIL overrun_latency got=%0d exp=3", cyc);
        end
        checks++;
        if ({overrun, dev, mean} !== {1'b1, ed, em}) begin
            failures++;
            $display("[TB] FAIL overrun_result got ovr=%b dev=%h mean=%h exp ovr=1 dev=%h mean=%h", overrun, dev, mean, ed, em);
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0 || overrun !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overrun_sticky got extra_pulses=%0d ovr=%b exp 0 and 1", extra, overrun);
        end

        @(negedge clk);
        x_in = 32'h0003_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0 || {busy, overrun, window_full, mean, dev} !== '0) begin
            failures++;
            $display("[TB] FAIL midop_reset got pulses=%0d busy=%b ovr=%b wf=%b mean=%h dev=%h exp all 0",
                     extra, busy, overrun, window_full, mean, dev);
        end
        @(negedge clk);
        reset = 1'b1;
        model_q.delete();
        drive_sample(32'h0005_0000, lat, o, d, m, wf);
        model_step(32'h0005_0000, eo, ed, em, ewf);
        checks++;
        if ({lat == 3, o, wf, d, m} !== {1'b1, 1'b0, 1'b0, 32'h0005_0000, 32'h0000_A000}) begin
            failures++;
            $display("[TB] FAIL after_reset_empty got lat=%0d outl=%b wf=%b dev=%h mean=%h exp lat=3 outl=0 wf=0 dev=00050000 mean=0000a000",
                     lat, o, wf, d, m);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic o, wf, eo, ewf;
        logic [31:0] d, m, ed, em;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_sample(ONE + 32'(i) * 32'h0000_4000, lat, o, d, m, wf);
            model_step(ONE + 32'(i) * 32'h0000_4000, eo, ed, em, ewf);
            checks++;
            if ({lat == 3, busy, d, m} !== {1'b1, 1'b0, ed, em}) begin
                failures++;
                $display("[TB] FAIL b2b[%0d] got lat=%0d busy=%b dev=%h mean=%h exp lat=3 busy=0 dev=%h mean=%h",
                         i, lat, busy, d, m, ed, em);
            end
        end
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_overrun got=%b exp=0", overrun);
        end
    endtask

    task automatic test_random();
        int lat;
        logic o, wf, eo, ewf;
        logic [31:0] d, m, ed, em, x;
        do_reset();
        warm_up_ones();
        for (int i = 0; i < 80; i++) begin
            if (i % 16 == 7)       x = 32'h8000_0000;
            else if (i % 16 == 15) x = 32'h7FFF_0000;
            else                   x = ONE + $urandom_range(0, 32'h6_0000) - 32'h3_0000;
            drive_sample(x, lat, o, d, m, wf);
            model_step(x, eo, ed, em, ewf);
            checks++;
            if ({lat == 3, o, wf, d, m} !== {1'b1, eo, ewf, ed, em}) begin
                failures++;
                $display("[TB] FAIL random[%0d] x=%h got lat=%0d outl=%b wf=%b dev=%h mean=%h exp outl=%b wf=%b dev=%h mean=%h",
                         i, x, lat, o, wf, d, m, eo, ewf, ed, em);
            end
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_positive_outlier();
        test_threshold_insert();
        test_negative_outlier();
        test_overrun_and_midop_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
